// File: rtl/bird_pkg.sv
// Shared types and screen constants for the bird launch receiver.
package bird_pkg;

    localparam int FIXED_BITS = 4;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;

    typedef logic signed [15:0] fx_t;

    typedef enum logic [2:0] {
        READY_ST,
        ARMED_ST,
        FLY_ST,
        HIT_ST,
        DONE_ST
    } bird_state_t;

endpackage

// File: rtl/bird_kinematics.sv
// One-frame ballistic step and screen-bounds test for a bird.
module bird_kinematics
    import bird_pkg::*;
#(
    parameter int FRAC_BITS = FIXED_BITS,
    parameter int GRAVITY   = 4,
    parameter int VY_MAX    = 256,
    parameter int X_MAX     = 639,
    parameter int Y_FLOOR   = 448
) (
    input  fx_t  pos_x,
    input  fx_t  pos_y,
    input  fx_t  vel_x,
    input  fx_t  vel_y,
    output fx_t  nxt_pos_x,
    output fx_t  nxt_pos_y,
    output fx_t  nxt_vel_x,
    output fx_t  nxt_vel_y,
    output logic out_of_bounds
);

    localparam fx_t GRAV_FX = fx_t'(GRAVITY);
    localparam fx_t VMAX_FX = fx_t'(VY_MAX);
    localparam logic signed [11:0] X_LIM = 12'(X_MAX);
    localparam logic signed [11:0] Y_LIM = 12'(Y_FLOOR);
    localparam logic signed [11:0] Y_TOP = -12'sd32;

    fx_t vy_sum;
    logic signed [11:0] pix_x;
    logic signed [11:0] pix_y;

    always_comb begin
        vy_sum    = vel_y + GRAV_FX;
        nxt_vel_y = (vy_sum > VMAX_FX) ? VMAX_FX : vy_sum;
        nxt_vel_x = vel_x;
        // position advances with the already-updated vertical speed
        nxt_pos_x = pos_x + vel_x;
        nxt_pos_y = pos_y + nxt_vel_y;
        pix_x     = 12'(pos_x >>> FRAC_BITS);
        pix_y     = 12'(pos_y >>> FRAC_BITS);
        out_of_bounds = (pix_x > X_LIM) ||
                        (pix_y >= Y_LIM) ||
                        (pix_y < Y_TOP);
    end

endmodule

// File: rtl/bird_flight.sv
// Per-bird launch receiver: arm on shoot, fly once per frame,
// report hit or miss and export position for drawing.
module bird_flight
    import bird_pkg::*;
#(
    parameter int FIXED_BITS = bird_pkg::FIXED_BITS,
    parameter int INIT_X     = 64,
    parameter int INIT_Y     = 352,
    parameter int INIT_VX    = 160,
    parameter int INIT_VY    = -192,
    parameter int GRAVITY    = 4,
    parameter int VY_MAX     = 256,
    parameter int X_MAX      = SCREEN_W - 1,
    parameter int Y_FLOOR    = SCREEN_H - 32,
    parameter int HIT_FRAMES = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               shoot_pulse,
    input  logic               reload,
    input  logic               startOfFrame,
    input  logic               collision,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               bird_visible,
    output logic               bird_busy,
    output logic               bird_hit,
    output logic               bird_missed
);

    localparam fx_t POS_X0 = fx_t'(INIT_X <<< FIXED_BITS);
    localparam fx_t POS_Y0 = fx_t'(INIT_Y <<< FIXED_BITS);
    localparam fx_t VEL_X0 = fx_t'(INIT_VX);
    localparam fx_t VEL_Y0 = fx_t'(INIT_VY);
    localparam logic [3:0] CNT_LAST = 4'(HIT_FRAMES - 1);

    bird_state_t state, state_n;
    fx_t posX, posY, velX, velY;
    fx_t posX_n, posY_n, velX_n, velY_n;
    fx_t kin_px, kin_py, kin_vx, kin_vy;
    logic [3:0] hit_cnt, hit_cnt_n;
    logic oob, hit_n, miss_n, busy_n, vis_n;

    bird_kinematics #(
        .FRAC_BITS (FIXED_BITS),
        .GRAVITY   (GRAVITY),
        .VY_MAX    (VY_MAX),
        .X_MAX     (X_MAX),
        .Y_FLOOR   (Y_FLOOR)
    ) u_kin (
        .pos_x         (posX),
        .pos_y         (posY),
        .vel_x         (velX),
        .vel_y         (velY),
        .nxt_pos_x     (kin_px),
        .nxt_pos_y     (kin_py),
        .nxt_vel_x     (kin_vx),
        .nxt_vel_y     (kin_vy),
        .out_of_bounds (oob)
    );

    always_comb begin
        state_n   = state;
        posX_n    = posX;
        posY_n    = posY;
        velX_n    = velX;
        velY_n    = velY;
        hit_cnt_n = hit_cnt;
        hit_n     = 1'b0;
        miss_n    = 1'b0;
        unique case (state)
            READY_ST: begin
                if (shoot_pulse) begin
                    state_n = ARMED_ST;
                    velX_n  = VEL_X0;
                    velY_n  = VEL_Y0;
                end
            end
            ARMED_ST: begin
                if (startOfFrame) state_n = FLY_ST;
            end
            FLY_ST: begin
                // collision outranks both the exit test and a frame step
                if (collision) begin
                    state_n   = HIT_ST;
                    hit_n     = 1'b1;
                    velX_n    = '0;
                    velY_n    = '0;
                    hit_cnt_n = '0;
                end else if (oob) begin
                    state_n = DONE_ST;
                    miss_n  = 1'b1;
                end else if (startOfFrame) begin
                    posX_n = kin_px;
                    posY_n = kin_py;
                    velX_n = kin_vx;
                    velY_n = kin_vy;
                end
            end
            HIT_ST: begin
                if (startOfFrame) begin
                    if (hit_cnt == CNT_LAST) state_n = DONE_ST;
                    else hit_cnt_n = hit_cnt + 4'd1;
                end
            end
            DONE_ST: begin
                if (reload) begin
                    state_n = READY_ST;
                    posX_n  = POS_X0;
                    posY_n  = POS_Y0;
                    velX_n  = '0;
                    velY_n  = '0;
                end
            end
            default: state_n = READY_ST;
        endcase
        busy_n = (state_n == ARMED_ST) || (state_n == FLY_ST) ||
                 (state_n == HIT_ST);
        vis_n  = (state_n != DONE_ST);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= READY_ST;
            posX         <= POS_X0;
            posY         <= POS_Y0;
            velX         <= '0;
            velY         <= '0;
            hit_cnt      <= '0;
            bird_visible <= 1'b1;
            bird_busy    <= 1'b0;
            bird_hit     <= 1'b0;
            bird_missed  <= 1'b0;
        end else begin
            state        <= state_n;
            posX         <= posX_n;
            posY         <= posY_n;
            velX         <= velX_n;
            velY         <= velY_n;
            hit_cnt      <= hit_cnt_n;
            bird_visible <= vis_n;
            bird_busy    <= busy_n;
            bird_hit     <= hit_n;
            bird_missed  <= miss_n;
        end
    end

    assign topLeftX = 11'(posX >>> FIXED_BITS);
    assign topLeftY = 11'(posY >>> FIXED_BITS);

endmodule
